// File: rtl/omega_packet_injector.sv
// Ingress stage for the 8-lane omega network: grants one packet per destination
// per slot (lowest lane wins) and serialises each granted packet into a slot-aligned frame.
module omega_packet_injector #(
    parameter int N         = 8,
    parameter int ADDR_W    = 3,
    parameter int PAYLOAD_W = 8,
    parameter int GAP       = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N-1:0]           in_valid,
    input  logic [N*ADDR_W-1:0]    in_dest,
    input  logic [N*PAYLOAD_W-1:0] in_data,
    output logic [N-1:0]           in_ready,
    output logic [N-1:0]           InDat,
    output logic                   frame_start,
    output logic [15:0]            conflict_cnt
);
    localparam int L      = 1 + ADDR_W + PAYLOAD_W + GAP;
    localparam int FCNT_W = $clog2(L);
    localparam int DEN_W  = $clog2(N + 1);
    localparam logic [FCNT_W-1:0] LAST = FCNT_W'(L - 1);

    logic [FCNT_W-1:0] fcnt;
    logic              grant_cycle;
    logic [N-1:0]      grant;
    logic [N-1:0]      claimed;
    logic [DEN_W-1:0]  denied;
    logic [16:0]       cnt_sum;
    logic [L-1:0]      shifter [N];

    // Handshake: a lane transfers when in_valid[i] & in_ready[i] on a rising edge.
    // in_ready is only ever raised in the grant cycle (last slot cycle, RST low);
    // sources hold valid/dest/data stable until that transfer.
    assign grant_cycle = (fcnt == LAST) && !RST;
    assign in_ready    = grant;
    assign cnt_sum     = {1'b0, conflict_cnt} + 17'(denied);

    // Destinations are one-hot tracked in claimed, valid because N == 2**ADDR_W.
    always_comb begin
        grant   = '0;
        claimed = '0;
        denied  = '0;
        if (grant_cycle) begin
            for (int i = 0; i < N; i++) begin
                if (in_valid[i]) begin
                    if (claimed[in_dest[i*ADDR_W +: ADDR_W]]) begin
                        denied = denied + DEN_W'(1);
                    end else begin
                        grant[i] = 1'b1;
                        claimed[in_dest[i*ADDR_W +: ADDR_W]] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        InDat = '0;
        for (int i = 0; i < N; i++) begin
            InDat[i] = shifter[i][L-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fcnt         <= '0;
            frame_start  <= 1'b0;
            conflict_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                shifter[i] <= '0;
            end
        end else begin
            fcnt         <= (fcnt == LAST) ? '0 : fcnt + FCNT_W'(1);
            frame_start  <= grant_cycle && (|grant);
            conflict_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            // Reload every lane at the slot boundary so ungranted lanes send an all-zero slot.
            for (int i = 0; i < N; i++) begin
                if (grant_cycle) begin
                    shifter[i] <= grant[i] ? {1'b1, in_dest[i*ADDR_W +: ADDR_W],
                                              in_data[i*PAYLOAD_W +: PAYLOAD_W], {GAP{1'b0}}}
                                           : '0;
                end else begin
                    shifter[i] <= shifter[i] << 1;
                end
            end
        end
    end
endmodule

// File: tb/tb_omega_packet_injector.sv
// Directed bench for omega_packet_injector: a driver issues slots and queues the
// expected whole-slot frame picture; a monitor captures each framed slot and compares.
module tb_omega_packet_injector;
    localparam int N  = 8;
    localparam int A  = 3;
    localparam int P  = 8;
    localparam int L  = 13;
    localparam int NL = N * L;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N*A-1:0] in_dest = '0;
    logic [N*P-1:0] in_data = '0;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   InDat;
    logic           frame_start;
    logic [15:0]    conflict_cnt;

    logic [NL-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [3:0]    tb_fcnt = '0;
    int            waited;

    omega_packet_injector dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data),
        .in_ready(in_ready), .InDat(InDat), .frame_start(frame_start),
        .conflict_cnt(conflict_cnt)
    );

    // clock / reference slot counter
    always #5 CLK = ~CLK;
    always @(posedge CLK) tb_fcnt <= RST ? 4'd0 : ((tb_fcnt == 4'(L - 1)) ? 4'd0 : tb_fcnt + 4'd1);

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NL-1:0] build_slot(input logic [N-1:0] g, input logic [N*A-1:0] d,
                                                 input logic [N*P-1:0] p);
        logic [NL-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) r[i*L +: L] = {1'b1, d[i*A +: A], p[i*P +: P], 1'b0};
        end
        return r;
    endfunction

    // Entered at posedge+1; returns at posedge+1 of the cycle after the grant.
    task automatic run_slot(input logic [N-1:0] v, input logic [N*A-1:0] d,
                            input logic [N*P-1:0] p, input logic [N-1:0] exp_rdy,
                            input logic [NL-1:0] exp_frame, output int n_wait);
        n_wait   = 0;
        in_valid = v;
        in_dest  = d;
        in_data  = p;
        #1;
        while (tb_fcnt != 4'(L - 1) && n_wait < 2 * L) begin
            check("ready_idle", 128'(in_ready), 128'(0));
            @(posedge CLK); #2;
            n_wait++;
        end
        check("ready_grant", 128'(in_ready), 128'(exp_rdy));
        if (exp_rdy != '0) exp_q.push_back(exp_frame);
        @(posedge CLK); #1;
        in_valid = '0;
    endtask

    // monitor / scoreboard
    initial begin : monitor
        logic [NL-1:0] cap;
        logic [NL-1:0] exp;
        forever begin
            @(negedge CLK);
            if (frame_start === 1'b1) begin
                check("frame_phase", 128'(tb_fcnt), 128'(0));
                cap = '0;
                for (int k = 0; k < L; k++) begin
                    if (k > 0) begin
                        @(negedge CLK);
                        check("frame_start_width", 128'(frame_start), 128'(0));
                    end
                    for (int i = 0; i < N; i++) cap[i*L + (L - 1 - k)] = InDat[i];
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 128'(cap), 128'(0));
                    if (cap == '0) begin
                        errors++;
                        $display("FAIL unexpected_frame act=frame_start exp=none");
                    end
                end else begin
                    exp = exp_q.pop_front();
                    check("slot_frame", 128'(cap), 128'(exp));
                end
            end else begin
                check("idle_indat", 128'(InDat), 128'(0));
            end
        end
    end

    initial begin : stimulus
        // 1: reset with all lanes valid
        in_valid = 8'hFF;
        repeat (3) begin
            @(posedge CLK); #1;
            check("rst_ready", 128'(in_ready), 128'(0));
            check("rst_indat", 128'(InDat), 128'(0));
            check("rst_conflict", 128'(conflict_cnt), 128'(0));
        end
        RST = 1'b0;
        in_valid = '0;

        // 2: single lane, hand-computed frame 1,101,10100101,0 on lane 2
        run_slot(8'h04, 24'(5) << 6, 64'hA5 << 16, 8'h04, NL'(13'b1101101001010) << 26, waited);
        check("first_grant_wait", 128'(waited), 128'(L - 1));
        check("conflict_t2", 128'(conflict_cnt), 128'(0));

        // 3: all lanes, distinct destinations 7..0
        run_slot(8'hFF, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 64'h8877665544332211,
                 8'hFF, build_slot(8'hFF, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
                                   64'h8877665544332211), waited);
        check("conflict_t3", 128'(conflict_cnt), 128'(0));

        // 4: lanes 1 and 6 both to dest 3; lane 6 retries next slot
        run_slot(8'h42, (24'd3 << 3) | (24'd3 << 18), (64'hC3 << 8) | (64'h7E << 48), 8'h02,
                 build_slot(8'h02, (24'd3 << 3) | (24'd3 << 18), (64'hC3 << 8) | (64'h7E << 48)),
                 waited);
        check("conflict_t4a", 128'(conflict_cnt), 128'(1));
        run_slot(8'h40, (24'd3 << 3) | (24'd3 << 18), (64'hC3 << 8) | (64'h7E << 48), 8'h40,
                 build_slot(8'h40, (24'd3 << 3) | (24'd3 << 18), (64'hC3 << 8) | (64'h7E << 48)),
                 waited);
        check("retry_wait", 128'(waited), 128'(L - 1));
        check("conflict_t4b", 128'(conflict_cnt), 128'(1));

        // 5: lane 0 streaming three back-to-back slots
        run_slot(8'h01, 24'd4, 64'h01, 8'h01, build_slot(8'h01, 24'd4, 64'h01), waited);
        run_slot(8'h01, 24'd4, 64'hFE, 8'h01, build_slot(8'h01, 24'd4, 64'hFE), waited);
        check("stream_wait1", 128'(waited), 128'(L - 1));
        run_slot(8'h01, 24'd4, 64'h55, 8'h01, build_slot(8'h01, 24'd4, 64'h55), waited);
        check("stream_wait2", 128'(waited), 128'(L - 1));

        // 6: reset at fcnt=6 of lane 3 frame 1,010,00111100,0 -> only k=0..6 survive
        run_slot(8'h08, 24'd2 << 9, 64'h3C << 24, 8'h08, NL'(13'b1010001000000) << 39, waited);
        for (int c = 0; c < L && tb_fcnt != 4'd6; c++) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("midrst_indat", 128'(InDat), 128'(0));
        check("midrst_conflict", 128'(conflict_cnt), 128'(0));
        run_slot(8'h20, 24'd6 << 15, 64'h5A << 40, 8'h20,
                 build_slot(8'h20, 24'd6 << 15, 64'h5A << 40), waited);
        check("post_rst_wait", 128'(waited), 128'(L - 1));

        // 7: reset coinciding with the grant cycle blocks the transfer
        in_valid = 8'h10;
        in_dest  = 24'd1 << 12;
        in_data  = 64'h99 << 32;
        for (int c = 0; c < L && tb_fcnt != 4'(L - 1); c++) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        #1;
        check("rst_grant_ready", 128'(in_ready), 128'(0));
        @(posedge CLK); #1;
        RST = 1'b0;
        in_valid = '0;

        repeat (3 * L) @(posedge CLK);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
